dma_rd_streamer: RTL and testbench

Read-side streamer directly downstream of the DMA control FSM. It accepts the FSM's per-descriptor read request (valid plus the selected descriptor's source address and byte count). It splits the descriptor into AXI4 AR bursts that respect the max burst length and 4KB boundaries, drives the AR channel, and pulses done back to the FSM once the last burst address has been accepted. R-data handling is done elsewhere.

---
 rtl/dma_rd_streamer.sv | 176 +++++++++++++++++
 tb/tb_dma_rd_streamer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module   : dma_rd_streamer
// Brief    : Splits one DMA descriptor into AXI4 AR bursts (max-length and
//            4KB-boundary aware) and pulses done once every burst is accepted.
// Revision : 1.0
// ============================================================================
module dma_rd_streamer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BYTES_W   = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               str_valid_i,
    input  logic [ADDR_W-1:0]  desc_addr_i,
    input  logic [BYTES_W-1:0] desc_bytes_i,
    input  logic               desc_fixed_i,
    output logic               done_o,
    output logic               busy_o,
    output logic               arvalid_o,
    input  logic               arready_i,
    output logic [ADDR_W-1:0]  araddr_o,
    output logic [7:0]         arlen_o,
    output logic [2:0]         arsize_o,
    output logic [1:0]         arburst_o
);

    localparam int c_bpb = DATA_W / 8;
    localparam int c_sz  = $clog2(c_bpb);
    localparam int c_rw  = BYTES_W + 1;
    localparam int c_cw  = (c_rw > 13) ? c_rw : 13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_REQ  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [c_rw-1:0]   rem_q, rem_d;
    logic              fixed_q, fixed_d;
    logic [8:0]        len_q, len_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [1:0]        arburst_q, arburst_d;

    logic [c_rw-1:0]   w_beats;
    logic [12:0]       w_page_room;
    logic [12:0]       w_page_beats;
    logic [c_cw-1:0]   w_cap;
    logic [c_cw-1:0]   w_len_full;
    logic [8:0]        w_len;
    logic              w_unused;

    // Extra bit on the beat count keeps ceil() from overflowing at max byte count
    assign w_beats      = (c_rw'(desc_bytes_i) + c_rw'(c_bpb - 1)) >> c_sz;
    assign w_page_room  = 13'd4096 - {1'b0, addr_q[11:0]};
    assign w_page_beats = w_page_room >> c_sz;

    always_comb begin
        w_cap = c_cw'(16);
        if (!fixed_q) begin
            w_cap = (c_cw'(w_page_beats) < c_cw'(MAX_BEATS)) ? c_cw'(w_page_beats)
                                                            : c_cw'(MAX_BEATS);
        end
        w_len_full = (c_cw'(rem_q) < w_cap) ? c_cw'(rem_q) : w_cap;
    end

    // Burst length never exceeds 256, so the upper bits are always zero
    assign w_len    = w_len_full[8:0];
    assign w_unused = ^w_len_full[c_cw-1:9];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        fixed_d   = fixed_q;
        len_d     = len_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arburst_d = arburst_q;
        case (state_q)
            S_IDLE: begin
                if (str_valid_i) begin
                    addr_d  = desc_addr_i & ~ADDR_W'(c_bpb - 1);
                    rem_d   = w_beats;
                    fixed_d = desc_fixed_i;
                    state_d = (w_beats == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (!str_valid_i) begin
                    state_d = S_IDLE;
                end else begin
                    len_d     = w_len;
                    araddr_d  = addr_q;
                    arlen_d   = 8'(w_len - 9'd1);
                    arburst_d = fixed_q ? 2'b00 : 2'b01;
                    arvalid_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // AR fields stay frozen until accepted, even if the request is withdrawn
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rem_d     = rem_q - c_rw'(len_q);
                    if (!fixed_q) begin
                        addr_d = addr_q + (ADDR_W'(len_q) << c_sz);
                    end
                    if (!str_valid_i) begin
                        state_d = S_IDLE;
                    end else if (rem_d == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            fixed_q   <= 1'b0;
            len_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arburst_q <= 2'b01;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            fixed_q   <= fixed_d;
            len_q     <= len_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arburst_q <= arburst_d;
        end
    end

    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign arvalid_o = arvalid_q;
    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign arsize_o  = 3'(c_sz);
    assign arburst_o = arburst_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_rd_streamer
// Brief    : Randomized and directed bench for dma_rd_streamer against a
//            burst-list reference model.
// Revision : 1.0
// ============================================================================
module tb_dma_rd_streamer;

    localparam int BPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        str_valid_i;
    logic [31:0] desc_addr_i;
    logic [31:0] desc_bytes_i;
    logic        desc_fixed_i;
    logic        done_o;
    logic        busy_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;

    dma_rd_streamer dut (
        .clk          (clk),
        .rst          (rst),
        .str_valid_i  (str_valid_i),
        .desc_addr_i  (desc_addr_i),
        .desc_bytes_i (desc_bytes_i),
        .desc_fixed_i (desc_fixed_i),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .araddr_o     (araddr_o),
        .arlen_o      (arlen_o),
        .arsize_o     (arsize_o),
        .arburst_o    (arburst_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_t;

    ar_t exp_q[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
        end
    endtask

    // Expected AR list derived straight from the burst-splitting rules
    task automatic build_model(input logic [31:0] a, input logic [31:0] b, input logic f);
        longint      beats;
        longint      len;
        longint      room;
        logic [31:0] ad;
        ar_t         e;
        exp_q.delete();
        beats = (longint'(b) + BPB - 1) / BPB;
        ad    = a & ~32'(BPB - 1);
        while (beats > 0) begin
            if (f) begin
                len = (beats < 16) ? beats : 16;
            end else begin
                room = (4096 - longint'(ad[11:0])) / BPB;
                len  = beats;
                if (len > 256)  len = 256;
                if (len > room) len = room;
            end
            e.addr  = ad;
            e.len   = 8'(len - 1);
            e.burst = f ? 2'b00 : 2'b01;
            exp_q.push_back(e);
            beats -= len;
            if (!f) ad = ad + 32'(len * BPB);
        end
    endtask

    task automatic run_desc(input logic [31:0] a, input logic [31:0] b, input logic f,
                            input int stall_pct);
        int idx, hs_idx, n_exp, n_hs, done_idx;
        bit first, prev_av, stalled, hs;
        build_model(a, b, f);
        n_exp    = exp_q.size();
        n_hs     = 0;
        idx      = 0;
        hs_idx   = -1;
        done_idx = -1;
        first    = 1'b1;
        prev_av  = 1'b0;
        desc_addr_i  = a;
        desc_bytes_i = b;
        desc_fixed_i = f;
        str_valid_i  = 1'b1;
        while (done_idx < 0 && idx < 4000) begin
            arready_i = ($urandom_range(0, 99) >= stall_pct);
            hs        = arvalid_o && arready_i;
            stalled   = arvalid_o && !arready_i;
            if (hs) begin
                if (exp_q.size() > 0) begin
                    check_eq("araddr", araddr_o, exp_q[0].addr);
                    check_eq("arlen", arlen_o, exp_q[0].len);
                    check_eq("arburst", arburst_o, exp_q[0].burst);
                    check_eq("arsize", arsize_o, 3'd2);
                    void'(exp_q.pop_front());
                end
                n_hs++;
                hs_idx = idx;
            end
            @(posedge clk); #1;
            idx++;
            if (stalled && exp_q.size() > 0) begin
                check_eq("stall_arvalid", arvalid_o, 1'b1);
                check_eq("stall_araddr", araddr_o, exp_q[0].addr);
                check_eq("stall_arlen", arlen_o, exp_q[0].len);
            end
            if (arvalid_o && !prev_av) begin
                check_eq("ar_latency", 64'(idx), 64'(first ? 2 : hs_idx + 2));
                first = 1'b0;
            end
            prev_av = arvalid_o;
            if (done_o) done_idx = idx;
        end
        check_eq("done_latency", 64'(done_idx), 64'(n_exp == 0 ? 1 : hs_idx + 1));
        check_eq("ar_count", 64'(n_hs), 64'(n_exp));
        str_valid_i = 1'b0;
        arready_i   = 1'b0;
        @(posedge clk); #1;
        check_eq("done_one_cycle", done_o, 1'b0);
        check_eq("busy_after_done", busy_o, 1'b0);
    endtask

    task automatic run_abort();
        int guard;
        bit saw;
        desc_addr_i  = 32'h2000;
        desc_bytes_i = 32'd2048;
        desc_fixed_i = 1'b0;
        str_valid_i  = 1'b1;
        arready_i    = 1'b0;
        guard = 0;
        while (!arvalid_o && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("abort_arvalid_up", arvalid_o, 1'b1);
        str_valid_i = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("abort_hold_valid", arvalid_o, 1'b1);
            check_eq("abort_hold_addr", araddr_o, 32'h2000);
            check_eq("abort_hold_len", arlen_o, 8'd255);
        end
        arready_i = 1'b1;
        @(posedge clk); #1;
        arready_i = 1'b0;
        check_eq("abort_arvalid_drop", arvalid_o, 1'b0);
        check_eq("abort_busy", busy_o, 1'b0);
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (arvalid_o || done_o || busy_o) saw = 1'b1;
        end
        check_eq("abort_quiet", saw, 1'b0);
    endtask

    task automatic run_reset_mid();
        int guard;
        desc_addr_i  = 32'h1000;
        desc_bytes_i = 32'd64;
        desc_fixed_i = 1'b0;
        str_valid_i  = 1'b1;
        arready_i    = 1'b0;
        guard = 0;
        while (!arvalid_o && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("rstmid_arvalid_up", arvalid_o, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rstmid_arvalid", arvalid_o, 1'b0);
        check_eq("rstmid_busy", busy_o, 1'b0);
        check_eq("rstmid_araddr", araddr_o, 32'h0);
        rst         = 1'b0;
        str_valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rf;
        rst          = 1'b1;
        str_valid_i  = 1'b0;
        desc_addr_i  = '0;
        desc_bytes_i = '0;
        desc_fixed_i = 1'b0;
        arready_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_arvalid", arvalid_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_araddr", araddr_o, 32'h0);
        check_eq("rst_arlen", arlen_o, 8'h0);
        check_eq("rst_arburst", arburst_o, 2'b01);
        check_eq("rst_arsize", arsize_o, 3'd2);
        rst = 1'b0;
        @(posedge clk); #1;

        run_desc(32'h0000_1000, 32'd64,   1'b0, 0);
        run_desc(32'h0000_0FF0, 32'd64,   1'b0, 0);
        run_desc(32'h0000_2000, 32'd2048, 1'b0, 0);
        run_desc(32'h0000_4000, 32'd5,    1'b0, 0);
        run_desc(32'h0000_3000, 32'd80,   1'b1, 0);
        run_desc(32'h0000_5000, 32'd0,    1'b0, 0);
        run_desc(32'h0000_1000, 32'd64,   1'b0, 70);
        run_desc(32'hFFFF_FFF2, 32'd40,   1'b0, 30);
        run_abort();
        run_reset_mid();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 3000));
            rf = ($urandom_range(0, 3) == 0);
            run_desc(ra, rb, rf, ($urandom_range(0, 1) == 1) ? 50 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
